// File: rtl/serial_right_shifter.sv
// Multi-cycle right shifter: logical, arithmetic or rotate, one bit per SHIFT cycle.
// Define SERIAL_SHIFTER_FAST_EN to take 4-bit steps while at least 4 bits of count remain.
module serial_right_shifter #(
  parameter int Width = 32
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [Width-1:0]         DataA,
  input  logic [$clog2(Width)-1:0] ShiftAmount,
  input  logic [1:0]               Mode,
  output logic                     Ready,
  output logic                     Done,
  output logic [Width-1:0]         Result
);

  localparam int CW = $clog2(Width);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [Width-1:0] work_r, work_s;
  logic [CW-1:0]    count_r, count_s;
  logic [1:0]       mode_r, mode_s;
  logic [Width-1:0] result_r, result_s;

  // Modes 0 and 3 (and anything unlisted) shift in zeros.
  function automatic logic [Width-1:0] step1(input logic [Width-1:0] v, input logic [1:0] m);
    logic [Width-1:0] r;
    case (m)
      2'd1:    r = {v[Width-1], v[Width-1:1]};
      2'd2:    r = {v[0], v[Width-1:1]};
      default: r = {1'b0, v[Width-1:1]};
    endcase
    return r;
  endfunction

`ifdef SERIAL_SHIFTER_FAST_EN
  function automatic logic [Width-1:0] step4(input logic [Width-1:0] v, input logic [1:0] m);
    logic [Width-1:0] r;
    case (m)
      2'd1:    r = {{4{v[Width-1]}}, v[Width-1:4]};
      2'd2:    r = {v[3:0], v[Width-1:4]};
      default: r = {4'b0000, v[Width-1:4]};
    endcase
    return r;
  endfunction
`endif

  // State, operand and result registers; reset abandons any operation in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r  <= IDLE;
      work_r   <= '0;
      count_r  <= '0;
      mode_r   <= 2'd0;
      result_r <= '0;
    end else begin
      state_r  <= state_s;
      work_r   <= work_s;
      count_r  <= count_s;
      mode_r   <= mode_s;
      result_r <= result_s;
    end
  end

  // Next-state logic; Result is loaded on the same edge that enters DONE.
  always_comb begin
    state_s  = state_r;
    work_s   = work_r;
    count_s  = count_r;
    mode_s   = mode_r;
    result_s = result_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          work_s  = DataA;
          count_s = ShiftAmount;
          mode_s  = Mode;
          if (ShiftAmount == '0) begin
            state_s  = DONE;
            result_s = DataA;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
`ifdef SERIAL_SHIFTER_FAST_EN
        if (count_r >= CW'(4)) begin
          work_s  = step4(work_r, mode_r);
          count_s = count_r - CW'(4);
        end else begin
          work_s  = step1(work_r, mode_r);
          count_s = count_r - CW'(1);
        end
`else
        work_s  = step1(work_r, mode_r);
        count_s = count_r - CW'(1);
`endif
        if (count_s == '0) begin
          state_s  = DONE;
          result_s = work_s;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign Ready  = (state_r == IDLE);
  assign Done   = (state_r == DONE);
  assign Result = result_r;

endmodule
